// File: rtl/led_count_arbiter_pkg.sv
// led_count_arbiter_pkg: shared state encodings, direction constants and defaults for the LED counting arbiter
package led_count_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic       DIR_UP       = 1'b0;
    localparam logic       DIR_DOWN     = 1'b1;
    localparam int         TICK_DIV_DEF = 1500000;
    localparam logic [3:0] CNT_MAX      = 4'hF;

    // Value loaded into the engine when a requester is granted
    function automatic logic [3:0] start_val(input logic dir);
        return (dir == DIR_DOWN) ? CNT_MAX : 4'h0;
    endfunction

    // Value at which a requester's sequence completes
    function automatic logic [3:0] terminal(input logic dir);
        return (dir == DIR_UP) ? CNT_MAX : 4'h0;
    endfunction

endpackage

// File: rtl/led_count_arbiter_if.sv
// led_count_arbiter_if: button requests in, LED count and status out
interface led_count_arbiter_if;
    logic [1:0] go_btn;
    logic [3:0] led;
    logic       busy;
    logic       owner;
    logic [1:0] done;

    modport master (output go_btn, input led, busy, owner, done);
    modport slave  (input go_btn, output led, busy, owner, done);
endinterface

// File: rtl/led_count_arbiter_tick_divider.sv
// led_count_arbiter_tick_divider: paces the count engine with one tick every TICK_DIV enabled cycles
module led_count_arbiter_tick_divider #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == W'(TICK_DIV - 1));

    // Count only while enabled, wrap on the tick, otherwise sit at zero
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) cnt <= '0;
        else          cnt <= (!en || tick) ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/led_count_arbiter.sv
// led_count_arbiter: round-robin sharing of one 4-bit LED up/down counting engine between two buttons
module led_count_arbiter
    import led_count_arbiter_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst_btn,
    led_count_arbiter_if.slave  bus
);
    logic [1:0] sync0, sync1, req, req_d, pending, pending_n, grant;
    logic [1:0] done_r, done_n;
    logic [3:0] led_r, led_n;
    logic       owner_r, owner_n, last_grant, last_n, sel, busy_r, tick;
    state_t     state, state_n;

    assign bus.led   = led_r;
    assign bus.busy  = busy_r;
    assign bus.owner = owner_r;
    assign bus.done  = done_r;

    // A new press wins over a same-cycle grant so no request is lost
    assign pending_n = (pending & ~grant) | (req & ~req_d);
    // Ties go to whoever was not served last
    assign sel = (pending == 2'b11) ? ~last_grant : pending[1];

    led_count_arbiter_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst_btn (rst_btn),
        .en      (state == ST_COUNT),
        .tick    (tick)
    );

    // Synchronize and invert the raw buttons, then latch rising edges as pending requests
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            sync0   <= '0;
            sync1   <= '0;
            req     <= '0;
            req_d   <= '0;
            pending <= '0;
        end else begin
            sync0   <= ~bus.go_btn;
            sync1   <= sync0;
            req     <= sync1;
            req_d   <= req;
            pending <= pending_n;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state      <= ST_IDLE;
            led_r      <= '0;
            owner_r    <= 1'b0;
            last_grant <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= '0;
        end else begin
            state      <= state_n;
            led_r      <= led_n;
            owner_r    <= owner_n;
            last_grant <= last_n;
            busy_r     <= (state_n != ST_IDLE);
            done_r     <= done_n;
        end
    end

    // Grant, step the count on each tick, and stop one tick after reaching the terminal value
    always_comb begin
        state_n = state;
        led_n   = led_r;
        owner_n = owner_r;
        last_n  = last_grant;
        done_n  = '0;
        grant   = '0;
        case (state)
            ST_IDLE: begin
                led_n = '0;
                if (|pending) begin
                    state_n    = ST_COUNT;
                    owner_n    = sel;
                    last_n     = sel;
                    led_n      = start_val(sel);
                    grant[sel] = 1'b1;
                end
            end
            ST_COUNT: begin
                if (tick) begin
                    if (led_r == terminal(owner_r)) begin
                        state_n         = ST_DONE;
                        done_n[owner_r] = 1'b1;
                    end else begin
                        led_n = (owner_r == DIR_UP) ? led_r + 4'd1 : led_r - 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                led_n   = '0;
            end
            default: begin
                state_n = ST_IDLE;
                led_n   = '0;
            end
        endcase
    end
endmodule
